// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register file slice.
package reg_file_pkg;
    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_word_t;
endpackage

// File: rtl/reg_file_demux_onehot_decoder.sv
// Binary index to one-hot vector, all zeros when en is low.
module onehot_decoder #(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   en,
    output logic [2**ADDR_W-1:0]   onehot
);
    always_comb begin
        onehot = '0;
        if (en)
            onehot[addr] = 1'b1;
    end
endmodule

// File: rtl/reg_file_demux.sv
// Register file: one demuxed write port, two bypassed read ports and a
// per-register pending-write scoreboard for the hazard unit.
module reg_file_demux
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
    parameter int DATA_W   = reg_file_pkg::DATA_W,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_rd,
    output logic                busy_a,
    output logic                busy_b,
    output logic [NUM_REGS-1:0] busy_vec
);
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_onehot;
    logic [NUM_REGS-1:0] issue_onehot;
    logic [NUM_REGS-1:0] busy_next;
    logic                wr_live;
    logic                hit_a;
    logic                hit_b;

    onehot_decoder #(.ADDR_W(ADDR_W)) u_wr_dec (
        .addr   (wr_addr),
        .en     (wr_en),
        .onehot (wr_onehot)
    );

    onehot_decoder #(.ADDR_W(ADDR_W)) u_issue_dec (
        .addr   (issue_rd),
        .en     (issue_en),
        .onehot (issue_onehot)
    );

    // Slot 0 is reset and never loaded, so it reads as a constant zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++)
                if (wr_onehot[i])
                    regs[i] <= wr_data;
        end
    end

    // Set beats clear: a newly issued producer supersedes the retiring one.
    always_comb begin
        busy_next    = (busy_vec & ~wr_onehot) | issue_onehot;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_vec <= '0;
        else
            busy_vec <= busy_next;
    end

    // Bypass is held off during reset so outputs show the cleared state.
    assign wr_live = rst_n & wr_en & (wr_addr != ADDR_W'(ZERO_REG));
    assign hit_a   = wr_live & (wr_addr == rd_addr_a);
    assign hit_b   = wr_live & (wr_addr == rd_addr_b);

    assign rd_data_a = hit_a ? wr_data : regs[rd_addr_a];
    assign rd_data_b = hit_b ? wr_data : regs[rd_addr_b];

    assign busy_a = busy_vec[rd_addr_a] & ~(wr_en & (wr_addr == rd_addr_a));
    assign busy_b = busy_vec[rd_addr_b] & ~(wr_en & (wr_addr == rd_addr_b));
endmodule

// File: tb/tb_reg_file_demux.sv
// Directed scoreboard bench for reg_file_demux.
module tb_reg_file_demux;
    import reg_file_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    reg_idx_t        wr_addr;
    reg_word_t       wr_data;
    reg_idx_t        rd_addr_a;
    reg_idx_t        rd_addr_b;
    reg_word_t       rd_data_a;
    reg_word_t       rd_data_b;
    logic            issue_en;
    reg_idx_t        issue_rd;
    logic            busy_a;
    logic            busy_b;
    logic [NUM_REGS-1:0] busy_vec;

    reg_file_demux #(.NUM_REGS(16), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] da;
        logic [31:0] db;
        logic        ba;
        logic        bb;
        logic [15:0] bv;
    } exp_t;

    exp_t expq[$];
    logic chk_vld = 1'b0;
    int   n_vec   = 0;
    int   n_fail  = 0;
    int   vec_id  = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec %0d %s: got 0x%08h expected 0x%08h", id, nm, act, exp);
        end
    endtask

    // Monitor: the DUT presents a result whenever chk_vld is raised.
    always @(negedge clk) begin
        if (chk_vld) begin
            if (expq.size() == 0) begin
                chk("queue_underflow", -1, 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("rd_data_a", e.id, rd_data_a, e.da);
                chk("rd_data_b", e.id, rd_data_b, e.db);
                chk("busy_a",    e.id, {31'd0, busy_a}, {31'd0, e.ba});
                chk("busy_b",    e.id, {31'd0, busy_b}, {31'd0, e.bb});
                chk("busy_vec",  e.id, {16'd0, busy_vec}, {16'd0, e.bv});
            end
        end
    end

    task automatic push_exp(input logic [31:0] da, input logic [31:0] db,
                            input logic ba, input logic bb, input logic [15:0] bv);
        exp_t e;
        e.id = vec_id; e.da = da; e.db = db; e.ba = ba; e.bb = bb; e.bv = bv;
        vec_id++;
        expq.push_back(e);
        chk_vld = 1'b1;
        @(negedge clk);
        #1 chk_vld = 1'b0;
    endtask

    task automatic drive(input logic we, input int wa, input logic [31:0] wd,
                         input logic ie, input int ir, input int ra, input int rb);
        wr_en = we; wr_addr = reg_idx_t'(wa); wr_data = wd;
        issue_en = ie; issue_rd = reg_idx_t'(ir);
        rd_addr_a = reg_idx_t'(ra); rd_addr_b = reg_idx_t'(rb);
    endtask

    task automatic step(input logic we, input int wa, input logic [31:0] wd,
                        input logic ie, input int ir, input int ra, input int rb,
                        input logic [31:0] da, input logic [31:0] db,
                        input logic ba, input logic bb, input logic [15:0] bv);
        @(posedge clk);
        #1 drive(we, wa, wd, ie, ir, ra, rb);
        push_exp(da, db, ba, bb, bv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 5, 1);
        #1 push_exp(32'h0, 32'h0, 0, 0, 16'h0000);
        rst_n = 1'b1;

        // reset state and write-back with bypass then storage
        step(0, 0, 32'h0,        0, 0, 5, 1,  32'h0,        32'h0,        0, 0, 16'h0000);
        step(1, 5, 32'hDEADBEEF, 0, 0, 5, 6,  32'hDEADBEEF, 32'h0,        0, 0, 16'h0000);
        step(0, 0, 32'h0,        0, 0, 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 16'h0000);
        step(0, 0, 32'h0,        0, 0, 4, 15, 32'h0,        32'h0,        0, 0, 16'h0000);
        // R0 protection
        step(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0,  32'h0,        32'h0,        0, 0, 16'h0000);
        step(0, 0, 32'h0,        0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 16'h0000);
        // scoreboard lifecycle on R3
        step(0, 0, 32'h0,        1, 3, 3, 5,  32'h0,        32'hDEADBEEF, 0, 0, 16'h0000);
        step(0, 0, 32'h0,        0, 0, 3, 5,  32'h0,        32'hDEADBEEF, 1, 0, 16'h0008);
        step(0, 0, 32'h0,        0, 0, 3, 3,  32'h0,        32'h0,        1, 1, 16'h0008);
        step(1, 3, 32'h12,       0, 0, 3, 3,  32'h12,       32'h12,       0, 0, 16'h0008);
        step(0, 0, 32'h0,        0, 0, 3, 3,  32'h12,       32'h12,       0, 0, 16'h0000);
        // simultaneous set and clear on R7, then retire
        step(1, 7, 32'h77,       1, 7, 7, 7,  32'h77,       32'h77,       0, 0, 16'h0000);
        step(0, 0, 32'h0,        0, 0, 7, 3,  32'h77,       32'h12,       1, 0, 16'h0080);
        step(1, 7, 32'h78,       0, 0, 7, 7,  32'h78,       32'h78,       0, 0, 16'h0080);
        step(0, 0, 32'h0,        0, 0, 7, 7,  32'h78,       32'h78,       0, 0, 16'h0000);
        // repeated issue to R4, single write clears
        step(0, 0, 32'h0,        1, 4, 4, 0,  32'h0,        32'h0,        0, 0, 16'h0000);
        step(0, 0, 32'h0,        1, 4, 4, 0,  32'h0,        32'h0,        1, 0, 16'h0010);
        step(1, 4, 32'h4,        0, 0, 4, 4,  32'h4,        32'h4,        0, 0, 16'h0010);
        step(0, 0, 32'h0,        0, 0, 4, 4,  32'h4,        32'h4,        0, 0, 16'h0000);
        // dual-port read of a retiring R9
        step(0, 0, 32'h0,        1, 9, 9, 9,  32'h0,        32'h0,        0, 0, 16'h0000);
        step(1, 9, 32'hA5A5A5A5, 0, 0, 9, 9,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 16'h0200);
        step(0, 0, 32'h0,        0, 0, 9, 9,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 16'h0000);
        // R2 = 0x55 left pending, then asynchronous reset between edges
        step(1, 2, 32'h55,       1, 2, 2, 5,  32'h55,       32'hDEADBEEF, 0, 0, 16'h0000);
        step(0, 0, 32'h0,        0, 0, 2, 5,  32'h55,       32'hDEADBEEF, 1, 0, 16'h0004);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 2, 5);
        #1 rst_n = 1'b0;
        push_exp(32'h0, 32'h0, 0, 0, 16'h0000);
        rst_n = 1'b1;
        // first edge after release accepts a write
        step(1, 2, 32'h66,       0, 0, 2, 5,  32'h66,       32'h0,        0, 0, 16'h0000);
        step(0, 0, 32'h0,        0, 0, 2, 5,  32'h66,       32'h0,        0, 0, 16'h0000);

        @(posedge clk);
        if (expq.size() != 0)
            chk("queue_leftover", -1, expq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_demux.md
# reg_file_demux

Register file with one write port, fed through a one-hot write demultiplexer, and two read ports. Its read ports drive the in0 operand inputs of the EX-stage 4:1 forwarding muxes. It also keeps a per-register pending-write scoreboard, so the hazard logic can decide between forwarding and stalling. It sits between the decode stage (reads and issue) and the write-back stage (writes).

## Interface
- NUM_REGS, 16: number of architectural registers; must be a power of two, at least 4.
- DATA_W, 32: register width.
- ADDR_W, $clog2(NUM_REGS): register index width; derived, never overridden.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_en  in  1  write-back strobe.
- wr_addr  in  ADDR_W  destination register of the write-back.
- wr_data  in  DATA_W  write-back value.
- rd_addr_a  in  ADDR_W  read port A index.
- rd_addr_b  in  ADDR_W  read port B index.
- rd_data_a  out  DATA_W  read port A data; combinational.
- rd_data_b  out  DATA_W  read port B data; combinational.
- issue_en  in  1  an instruction with a destination register is issued this cycle.
- issue_rd  in  ADDR_W  destination of the issued instruction.
- busy_a  out  1  register at rd_addr_a has an outstanding write.
- busy_b  out  1  register at rd_addr_b has an outstanding write.
- busy_vec  out  NUM_REGS  full scoreboard; bit i is set while register i is pending.

## Operation
- **Storage:** NUM_REGS x DATA_W flops. R0 reads as 0. Writes to R0 are discarded, and R0 is never marked busy.
- **Write path:** wr_addr is decoded to a one-hot enable vector, gated by wr_en. The selected register loads wr_data on the rising clk edge.
- **Read path:** asynchronous. rd_data_x = regs[rd_addr_x].
  - Write-first bypass: if wr_en is high, wr_addr equals rd_addr_x, and wr_addr is not 0, then rd_data_x = wr_data in the same cycle.
- **Scoreboard, per bit i (i ≠ 0), evaluated each edge:**
  - Set when issue_en is high and issue_rd = i.
  - Clear when wr_en is high and wr_addr = i.
  - Set and clear on the same register in the same cycle: set wins. A new producer supersedes the retiring one.
- **Busy outputs:** busy_x = busy_vec[rd_addr_x] & ~(wr_en & wr_addr == rd_addr_x). A write retiring this cycle is visible through the bypass, so it does not count as busy.
- **Extra writes:** a write to a register that is not busy is legal. It updates data and leaves the busy bit at 0.
- **Repeated issue:** issuing to an already-busy register is legal. The bit stays 1. Writes are not counted; a single write clears the bit.
- **Reset:** all registers become 0 and busy_vec becomes 0, immediately on rst_n low, independent of clk. An in-flight write in the reset cycle is lost. Outputs track the reset state combinationally while rst_n is low.

## Timing
- **Read latency:** 0 cycles (combinational from rd_addr_x and from the bypass inputs).
- **Write:** visible through storage one edge after wr_en. It is visible the same cycle through the bypass.
- **Issue:** busy_x rises the cycle after issue_en.
- **Retire:** busy_x drops in the cycle wr_en is presented (through the bypass mask). The stored bit clears at the following edge.
- **Release:** rst_n deassertion must meet recovery/removal relative to clk. The first write is accepted on the first edge after release.
- **Critical path:** rd_addr → read mux → forwarding mux → ALU. The read mux must be a flat NUM_REGS:1 selection with no extra logic levels beyond the bypass compare.

## Structure
- **Package reg_file_pkg:**
  - Constants: NUM_REGS, DATA_W, ADDR_W, ZERO_REG = 0.
  - Typedefs: reg_idx_t (logic [ADDR_W-1:0]) and reg_word_t (logic [DATA_W-1:0]).
- **Sub-module onehot_decoder:** parameterized by ADDR_W. Inputs are addr and en; output is a one-hot vector of 2^ADDR_W bits. It is instantiated twice: once for the write enables and once for the issue set-vector.

## Test plan
1. **Reset and write-back:** reset, then write R5 = 0xDEADBEEF. rd_addr_a = 5 returns 0xDEADBEEF in the same cycle (bypass) and in the next cycle (storage). All other registers read 0.
2. **R0 protection:** wr_en with wr_addr = 0 and wr_data = 0xFFFFFFFF, plus issue_en with issue_rd = 0. rd_data_a at address 0 stays 0. busy_vec[0] stays 0.
3. **Scoreboard lifecycle:** issue R3 in cycle 1, so busy_a = 1 for rd_addr_a = 3 from cycle 2. Write R3 = 0x12 in cycle 4: busy_a = 0 and rd_data_a = 0x12 in cycle 4. busy_vec[3] = 0 from cycle 5.
4. **Simultaneous set and clear:** issue_rd = 7 and wr_addr = 7 in the same cycle. busy_vec[7] = 1 after the edge, and R7 holds the new data.
5. **Dual-port read:** rd_addr_a = rd_addr_b = 9 while writing R9 = 0xA5A5A5A5. Both ports return 0xA5A5A5A5 and busy_a = busy_b = 0.
6. **Asynchronous reset mid-operation:** assert rst_n low between clock edges with R2 = 0x55 and busy_vec[2] = 1. rd_data at R2 = 0 and busy_vec = 0 before the next clk edge.
